// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type and
// default sizing for the receive FIFO.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AF    = 12;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the UART RX FIFO.
// Synchronous write, asynchronous read, no reset.
module fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX byte FIFO with first-word-fall-through
// output register, fill level and sticky stall flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  parameter int AF_LEVEL   = UART_FIFO_AF,
  localparam int AW        = $clog2(DEPTH),
  localparam int PW        = AW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_vld_i,
  output logic                  wr_rdy_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_vld_o,
  input  logic                  rd_rdy_i,
  output logic [PW-1:0]         level_o,
  output logic                  almost_full_o,
  output logic                  stall_o
);

  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic [PW-1:0]         level_q;
  logic [PW-1:0]         level_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rd_vld_q;
  logic                  wr_rdy_q;
  logic                  af_q;
  logic                  stall_q;

  logic wr_fire;
  logic rd_fire;
  logic st_empty;
  logic head_free;
  logic load_mem;
  logic bypass;
  logic mem_we;

  always_comb begin
    wr_fire   = wr_vld_i & wr_rdy_q;
    rd_fire   = rd_vld_q & rd_rdy_i;
    st_empty  = (wptr_q == rptr_q);
    head_free = ~rd_vld_q | rd_fire;
    load_mem  = head_free & ~st_empty;
    // empty storage: a write goes straight to the output register
    bypass    = head_free & st_empty & wr_fire;
    mem_we    = wr_fire & ~bypass;
    level_d   = level_q + PW'(wr_fire) - PW'(rd_fire);
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      wr_rdy_q  <= 1'b0;
      af_q      <= 1'b0;
      stall_q   <= 1'b0;
    end else if (flush_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      rd_vld_q  <= 1'b0;
      wr_rdy_q  <= 1'b1;
      af_q      <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      if (mem_we) wptr_q <= wptr_q + 1'b1;
      if (load_mem) begin
        rd_data_q <= mem_rdata;
        rptr_q    <= rptr_q + 1'b1;
        rd_vld_q  <= 1'b1;
      end else if (bypass) begin
        rd_data_q <= wr_data_i;
        rd_vld_q  <= 1'b1;
      end else if (head_free) begin
        rd_vld_q  <= 1'b0;
      end
      level_q  <= level_d;
      wr_rdy_q <= (level_d < PW'(DEPTH));
      af_q     <= (level_d >= PW'(AF_LEVEL));
      if (wr_vld_i && !wr_rdy_q) stall_q <= 1'b1;
    end
  end

  assign wr_rdy_o      = wr_rdy_q;
  assign rd_data_o     = rd_data_q;
  assign rd_vld_o      = rd_vld_q;
  assign level_o       = level_q;
  assign almost_full_o = af_q;
  assign stall_o       = stall_q;

endmodule
